ntt_bram_arbiter: RTL and testbench
===================================

NTT_BRAM_ARBITER -- requirements
Module: ntt_bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, coefficient BRAM word address width (256 coefficients).
REQ-002 SHALL have parameter DATA_W, default 12, coefficient width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports, in this order:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  synchronous active-low reset
- start_i  in  1  control-register start bit, level
- mode_i  in  1  0=NTT, 1=iNTT
- host_en_i / host_we_i  in  1 / 1  AXI-side BRAM enable / write
- host_addr_i / host_din_i  in  ADDR_W / DATA_W  AXI-side address / write data
- host_dout_o  out  DATA_W  AXI-side read data
- host_ready_o  out  1  host owns BRAM
- eng_start_o / eng_mode_o  out  1 / 1  engine launch pulse / latched mode
- eng_req_i / eng_we_i  in  1 / 1  engine BRAM enable / write
- eng_addr_i / eng_din_i  in  ADDR_W / DATA_W  engine address / write data
- eng_dout_o  out  DATA_W  engine read data
- eng_done_i  in  1  engine finished, one-cycle pulse
- bram_en_o / bram_we_o  out  1 / 1  BRAM enable / write
- bram_addr_o / bram_din_o  out  ADDR_W / DATA_W  BRAM address / write data
- bram_dout_i  in  DATA_W  BRAM read data, 1-cycle latency
- busy_o / done_o / irq_o / error_o  out  1 each  status

Function
REQ-005 FSM states SHALL be IDLE, LAUNCH, RUN, FINISH.
REQ-006 start_i rising edge SHALL be detected from a registered copy of start_i; a held level SHALL NOT relaunch.
REQ-007 IDLE: host_ready_o=1; BRAM ports SHALL mirror host_* combinationally; on start edge go to LAUNCH, latch mode_i into eng_mode_o, clear done_o and error_o.
REQ-008 A host access and a start edge in the same IDLE cycle SHALL both take effect: host access issues, then the FSM moves to LAUNCH.
REQ-009 LAUNCH: lasts exactly 1 cycle; bram_en_o=0; eng_start_o=1; then RUN. This cycle drains any host read issued in the final IDLE cycle.
REQ-010 RUN: bram ports SHALL mirror eng_* when eng_req_i=1; bram_en_o=0 and bram_we_o=0 otherwise; busy_o=1; on eng_done_i go to FINISH.
REQ-011 FINISH: 1 cycle; irq_o=1 for that cycle only; done_o set (sticky) and held until the next start edge; then IDLE.
REQ-012 busy_o SHALL be 1 in LAUNCH, RUN and FINISH.
REQ-013 host_dout_o SHALL register bram_dout_i one cycle after a host read (host_en_i=1, host_we_i=0) was issued, and hold otherwise.
REQ-014 eng_dout_o SHALL equal bram_dout_i combinationally.
REQ-015 A host access while host_ready_o=0 SHALL be dropped (no BRAM effect) and SHALL set error_o (sticky).
REQ-016 A start edge while busy_o=1 SHALL be ignored and SHALL set error_o.
REQ-017 eng_done_i outside RUN SHALL be ignored. eng_req_i outside RUN SHALL NOT reach the BRAM.

Reset
REQ-018 With s00_axi_aresetn=0 at a clock edge: FSM=IDLE, all status outputs 0, eng_start_o=0, eng_mode_o=0, host_dout_o=0, start edge register=0.
REQ-019 Reset mid-RUN SHALL abort to IDLE without irq_o. The next post-reset cycle with start_i=1 is not an edge, because the edge register is loaded from start_i.

Configuration
REQ-020 With NTT_ARB_VIOL_CNT_EN defined: add output viol_cnt_o [7:0], incremented per REQ-015/REQ-016 event, saturating at 255, cleared by reset only.
REQ-021 Without the macro: no port and no counter logic.

Structure
REQ-022 The FSM state enum and the constants NTT_N=256 and NTT_Q=3329 SHALL reside in the shared NTT package.
REQ-023 Sub-module ntt_start_edge (registered rising-edge detector) SHALL be used for start_i.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Host writes 0x0A5 to addr 7, reads addr 7 -> host_dout_o=0x0A5 one cycle after the read; error_o=0.
- start_i 0->1 with mode_i=1 -> LAUNCH next cycle; eng_start_o pulses once; eng_mode_o=1; busy_o=1; holding start_i high causes no relaunch.
- In RUN, host write 0x123 to addr 3 -> BRAM unchanged; error_o=1; with macro, viol_cnt_o=1; engine write 0x456 to addr 3 lands in BRAM.
- eng_done_i pulse -> irq_o high for exactly 1 cycle; done_o=1 until the next start edge; host_ready_o=1 after FINISH.
- Host read of addr 5 coincident with the start edge -> read data returns correctly during LAUNCH; no engine access in that cycle.
- Reset asserted mid-RUN with start_i held 1 -> IDLE; no irq_o; no launch after reset release until start_i toggles 0->1; with macro, 256 violations -> viol_cnt_o=255.

Source files
------------

// File: rtl/ntt_bram_arbiter_pkg.sv
// rtl/ntt_bram_arbiter_pkg.sv - shared NTT types and constants for the BRAM arbiter
package ntt_bram_arbiter_pkg;

    localparam int NTT_N = 256;
    localparam int NTT_Q = 3329;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ntt_start_edge.sv
// rtl/ntt_start_edge.sv - registered rising-edge detector for the start control bit
module ntt_start_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic armed_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sig_q   <= sig_i;
            armed_q <= 1'b1;
        end
    end

    // The first post-reset cycle only loads sig_q, so a level held across reset is not an edge.
    assign rise_o = armed_q & sig_i & ~sig_q;

endmodule

// File: rtl/ntt_bram_arbiter.sv
// rtl/ntt_bram_arbiter.sv - host/engine BRAM arbiter with launch FSM; NTT_ARB_VIOL_CNT_EN adds viol_cnt_o
module ntt_bram_arbiter
    import ntt_bram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              host_en_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_din_i,
    output logic [DATA_W-1:0] host_dout_o,
    output logic              host_ready_o,
    output logic              eng_start_o,
    output logic              eng_mode_o,
    input  logic              eng_req_i,
    input  logic              eng_we_i,
    input  logic [ADDR_W-1:0] eng_addr_i,
    input  logic [DATA_W-1:0] eng_din_i,
    output logic [DATA_W-1:0] eng_dout_o,
    input  logic              eng_done_i,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    input  logic [DATA_W-1:0] bram_dout_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              irq_o,
    output logic              error_o
`ifdef NTT_ARB_VIOL_CNT_EN
    ,
    output logic [7:0]        viol_cnt_o
`endif
);

    arb_state_e        state_q;
    logic              start_rise;
    logic              host_rd_q;
    logic [DATA_W-1:0] host_dout_q;
    logic              eng_start_q;
    logic              eng_mode_q;
    logic              busy_q;
    logic              done_q;
    logic              irq_q;
    logic              error_q;
    logic              host_viol;
    logic              start_viol;

    ntt_start_edge u_start_edge (
        .clk_i  (s00_axi_aclk),
        .rst_ni (s00_axi_aresetn),
        .sig_i  (start_i),
        .rise_o (start_rise)
    );

    assign host_ready_o = (state_q == ST_IDLE);
    assign host_viol    = host_en_i & ~host_ready_o;
    assign start_viol   = start_rise & busy_q;
    assign eng_dout_o   = bram_dout_i;

    always_comb begin
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        bram_din_o  = '0;
        if (state_q == ST_IDLE) begin
            bram_en_o   = host_en_i;
            bram_we_o   = host_en_i & host_we_i;
            bram_addr_o = host_addr_i;
            bram_din_o  = host_din_i;
        end else if (state_q == ST_RUN) begin
            bram_en_o   = eng_req_i;
            bram_we_o   = eng_req_i & eng_we_i;
            bram_addr_o = eng_addr_i;
            bram_din_o  = eng_din_i;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q     <= ST_IDLE;
            host_rd_q   <= 1'b0;
            host_dout_q <= '0;
            eng_start_q <= 1'b0;
            eng_mode_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            host_rd_q   <= host_ready_o & host_en_i & ~host_we_i;
            if (host_rd_q) begin
                host_dout_q <= bram_dout_i;
            end
            eng_start_q <= 1'b0;
            irq_q       <= 1'b0;
            if (host_viol || start_viol) begin
                error_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_q     <= ST_LAUNCH;
                        eng_start_q <= 1'b1;
                        eng_mode_q  <= mode_i;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                ST_LAUNCH: state_q <= ST_RUN;
                ST_RUN: begin
                    if (eng_done_i) begin
                        state_q <= ST_FINISH;
                        irq_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign host_dout_o = host_dout_q;
    assign eng_start_o = eng_start_q;
    assign eng_mode_o  = eng_mode_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign irq_o       = irq_q;
    assign error_o     = error_q;

`ifdef NTT_ARB_VIOL_CNT_EN
    logic [7:0] viol_cnt_q;
    logic [8:0] viol_sum;

    assign viol_sum = {1'b0, viol_cnt_q} + {8'd0, host_viol} + {8'd0, start_viol};

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            viol_cnt_q <= 8'd0;
        end else begin
            viol_cnt_q <= viol_sum[8] ? 8'hFF : viol_sum[7:0];
        end
    end

    assign viol_cnt_o = viol_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// tb/tb_ntt_bram_arbiter.sv - self-checking bench for ntt_bram_arbiter with a BRAM model
module tb_ntt_bram_arbiter;

    localparam int AW = 8;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start_i, mode_i;
    logic          host_en, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_din;
    logic [DW-1:0] host_dout_o;
    logic          host_ready_o, eng_start_o, eng_mode_o;
    logic          eng_req, eng_we, eng_done;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_din;
    logic [DW-1:0] eng_dout_o;
    logic          bram_en_o, bram_we_o;
    logic [AW-1:0] bram_addr_o;
    logic [DW-1:0] bram_din_o;
    logic [DW-1:0] bram_dout_i = '0;
    logic          busy_o, done_o, irq_o, error_o;
`ifdef NTT_ARB_VIOL_CNT_EN
    logic [7:0]    viol_cnt_o;
`endif

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    int            checks   = 0;
    int            failures = 0;
    int            exp_viol = 0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    always #5 clk = ~clk;

    ntt_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (resetn),
        .start_i         (start_i),
        .mode_i          (mode_i),
        .host_en_i       (host_en),
        .host_we_i       (host_we),
        .host_addr_i     (host_addr),
        .host_din_i      (host_din),
        .host_dout_o     (host_dout_o),
        .host_ready_o    (host_ready_o),
        .eng_start_o     (eng_start_o),
        .eng_mode_o      (eng_mode_o),
        .eng_req_i       (eng_req),
        .eng_we_i        (eng_we),
        .eng_addr_i      (eng_addr),
        .eng_din_i       (eng_din),
        .eng_dout_o      (eng_dout_o),
        .eng_done_i      (eng_done),
        .bram_en_o       (bram_en_o),
        .bram_we_o       (bram_we_o),
        .bram_addr_o     (bram_addr_o),
        .bram_din_o      (bram_din_o),
        .bram_dout_i     (bram_dout_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .irq_o           (irq_o),
        .error_o         (error_o)
`ifdef NTT_ARB_VIOL_CNT_EN
        ,
        .viol_cnt_o      (viol_cnt_o)
`endif
    );

    // Single-port BRAM, one-cycle read latency
    always @(posedge clk) begin
        if (bram_en_o) begin
            if (bram_we_o) mem[bram_addr_o] <= bram_din_o;
            else           bram_dout_i      <= mem[bram_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_viol(input string tag);
`ifdef NTT_ARB_VIOL_CNT_EN
        chk(tag, 32'(viol_cnt_o), 32'(exp_viol));
`endif
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        host_en = 1'b1; host_we = 1'b1; host_addr = wa; host_din = wd;
        tick();
        host_en = 1'b0; host_we = 1'b0;
        ref_mem[wa] = wd;
    endtask

    task automatic host_read_chk(input logic [AW-1:0] ra, input string tag);
        host_en = 1'b1; host_we = 1'b0; host_addr = ra;
        tick();
        host_en = 1'b0;
        tick();
        chk(tag, 32'(host_dout_o), 32'(ref_mem[ra]));
    endtask

    task automatic add_viol(input int n);
        exp_viol = (exp_viol + n > 255) ? 255 : exp_viol + n;
    endtask

    initial begin
        resetn = 1'b0; start_i = 1'b0; mode_i = 1'b0;
        host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
        eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_din = '0; eng_done = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(host_ready_o), 32'h1);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_error", 32'(error_o), 32'h0);
        chk("rst_eng_start", 32'(eng_start_o), 32'h0);
        chk("rst_eng_mode", 32'(eng_mode_o), 32'h0);
        chk("rst_host_dout", 32'(host_dout_o), 32'h0);
        chk_viol("rst_viol");
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) host_write(8'(i), 12'h000);

        host_write(8'd7, 12'h0A5);
        host_read_chk(8'd7, "host_rd7");
        chk("idle_error", 32'(error_o), 32'h0);

        eng_done = 1'b1; eng_req = 1'b1; eng_we = 1'b1; eng_addr = 8'd9; eng_din = 12'h777;
        #1;
        chk("idle_eng_blocked", 32'(bram_en_o), 32'h0);
        tick();
        eng_done = 1'b0; eng_req = 1'b0; eng_we = 1'b0;
        chk("idle_done_ignored_irq", 32'(irq_o), 32'h0);
        chk("idle_done_ignored_busy", 32'(busy_o), 32'h0);
        chk("idle_eng_no_write", 32'(mem[9]), 32'(ref_mem[9]));

        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) host_write(a, 12'($urandom));
            else                           host_read_chk(a, "rand_host_rd");
        end
        host_write(8'd5, 12'h2C7);

        mode_i = 1'b1; start_i = 1'b1;
        tick();
        chk("launch_eng_start", 32'(eng_start_o), 32'h1);
        chk("launch_eng_mode", 32'(eng_mode_o), 32'h1);
        chk("launch_busy", 32'(busy_o), 32'h1);
        chk("launch_ready", 32'(host_ready_o), 32'h0);
        chk("launch_bram_en", 32'(bram_en_o), 32'h0);
        tick();
        chk("run_eng_start_low", 32'(eng_start_o), 32'h0);
        chk("run_busy", 32'(busy_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_start_no_relaunch", 32'(eng_start_o), 32'h0);
        end

        host_en = 1'b1; host_we = 1'b1; host_addr = 8'd3; host_din = 12'h123;
        #1;
        chk("run_host_blocked", 32'(bram_en_o), 32'h0);
        tick();
        host_en = 1'b0; host_we = 1'b0;
        add_viol(1);
        chk("run_host_error", 32'(error_o), 32'h1);
        chk("run_host_no_write", 32'(mem[3]), 32'(ref_mem[3]));
        chk_viol("run_viol_one");

        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 8'd3; eng_din = 12'h456;
        #1;
        chk("run_eng_en", 32'(bram_en_o), 32'h1);
        chk("run_eng_addr", 32'(bram_addr_o), 32'h3);
        tick();
        eng_req = 1'b0; eng_we = 1'b0;
        ref_mem[3] = 12'h456;
        chk("run_eng_write", 32'(mem[3]), 32'h456);

        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 12'($urandom);
            eng_req = 1'b1; eng_addr = a; eng_din = d;
            eng_we = ($urandom_range(0, 1) == 1);
            host_en = ($urandom_range(0, 3) == 0);
            host_we = 1'b1; host_addr = 8'($urandom); host_din = 12'($urandom);
            if (host_en) add_viol(1);
            tick();
            host_en = 1'b0; host_we = 1'b0;
            if (eng_we) ref_mem[a] = d;
            else        chk("run_eng_read", 32'(eng_dout_o), 32'(ref_mem[a]));
            eng_req = 1'b0; eng_we = 1'b0;
        end
        chk_viol("run_viol_rand");

        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("finish_irq", 32'(irq_o), 32'h1);
        chk("finish_done", 32'(done_o), 32'h1);
        chk("finish_busy", 32'(busy_o), 32'h1);
        tick();
        chk("post_irq_low", 32'(irq_o), 32'h0);
        chk("post_done_sticky", 32'(done_o), 32'h1);
        chk("post_busy", 32'(busy_o), 32'h0);
        chk("post_ready", 32'(host_ready_o), 32'h1);
        chk("post_error_sticky", 32'(error_o), 32'h1);
        host_read_chk(8'd3, "readback3");
        a = 8'($urandom_range(0, 255));
        host_read_chk(a, "readback_rand");
        chk("done_still_set", 32'(done_o), 32'h1);

        start_i = 1'b0;
        tick();
        mode_i = 1'b0; start_i = 1'b1;
        host_en = 1'b1; host_we = 1'b0; host_addr = 8'd5;
        tick();
        host_en = 1'b0;
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 8'd5; eng_din = 12'hFFF;
        #1;
        chk("coinc_launch_no_eng", 32'(bram_en_o), 32'h0);
        chk("coinc_eng_start", 32'(eng_start_o), 32'h1);
        chk("coinc_done_cleared", 32'(done_o), 32'h0);
        chk("coinc_error_cleared", 32'(error_o), 32'h0);
        chk("coinc_mode", 32'(eng_mode_o), 32'h0);
        tick();
        eng_req = 1'b0; eng_we = 1'b0;
        chk("coinc_host_dout", 32'(host_dout_o), 32'(ref_mem[5]));
        chk("coinc_no_eng_write", 32'(mem[5]), 32'(ref_mem[5]));

        resetn = 1'b0;
        tick();
        exp_viol = 0;
        chk("midrst_busy", 32'(busy_o), 32'h0);
        chk("midrst_irq", 32'(irq_o), 32'h0);
        chk("midrst_ready", 32'(host_ready_o), 32'h1);
        chk("midrst_done", 32'(done_o), 32'h0);
        chk_viol("midrst_viol");
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_no_launch", 32'(eng_start_o), 32'h0);
            chk("postrst_busy", 32'(busy_o), 32'h0);
            chk("postrst_irq", 32'(irq_o), 32'h0);
        end
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        chk("relaunch_start", 32'(eng_start_o), 32'h1);
        chk("relaunch_busy", 32'(busy_o), 32'h1);
        tick();
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        add_viol(1);
        chk("busy_start_error", 32'(error_o), 32'h1);
        chk("busy_start_no_launch", 32'(eng_start_o), 32'h0);
        chk_viol("busy_start_viol");
`ifdef NTT_ARB_VIOL_CNT_EN
        host_en = 1'b1; host_we = 1'b0;
        repeat (260) tick();
        host_en = 1'b0;
        add_viol(260);
        chk_viol("viol_saturate");
`endif
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        tick();
        chk("end_busy", 32'(busy_o), 32'h0);
        chk("end_done", 32'(done_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
